anode_scanner: RTL and testbench

Time-multiplexing controller for the four-digit seven-segment display. It generates the active-low anode pattern `AN` that drives the display anodes and selects which digit the cathode multiplexer places on `CA`. A refresh prescaler sets the per-digit slot length. Each slot opens with a programmable dead time in which all anodes are off, to suppress ghosting. A per-digit blank mask lets upstream logic suppress digits such as leading zeros.

---
 rtl/anode_scanner_if.sv | 32 +++
 rtl/anode_scanner.sv | 79 +++++++
 tb/tb_anode_scanner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/anode_scanner_if.sv
// anode_scanner_if
// Groups the scan-control inputs and the display-drive outputs of the
// four-digit anode scanner.
//   en          : scan enable (low freezes the scan and darkens the display)
//   blank_mask  : per-digit dark mask, bit i keeps digit i off for its slot
//   AN          : active-low anode drive, at most one bit low
//   digit_sel   : index of the current digit slot (0..3)
//   slot_tick   : one-cycle pulse in the first cycle of each new slot
// master = upstream controller, slave = the scanner itself.
interface anode_scanner_if;
  logic       en;
  logic [3:0] blank_mask;
  logic [3:0] AN;
  logic [1:0] digit_sel;
  logic       slot_tick;

  modport master (
    output en,
    output blank_mask,
    input  AN,
    input  digit_sel,
    input  slot_tick
  );

  modport slave (
    input  en,
    input  blank_mask,
    output AN,
    output digit_sel,
    output slot_tick
  );
endinterface

// File: rtl/anode_scanner.sv
// anode_scanner
// Time-multiplexes a four-digit seven-segment display. A prescaler divides
// the clock into digit slots of REFRESH_DIV cycles; each slot starts with
// BLANK_CYC cycles of all-anodes-off dead time to suppress ghosting.
// Ports:
//   clk    : system clock, everything changes on its rising edge
//   rst_n  : synchronous active-low reset
//   bus    : anode_scanner_if slave (en, blank_mask in; AN, digit_sel,
//            slot_tick out), all outputs registered
module anode_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int CNT_W       = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  anode_scanner_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       an_q, an_d;
  logic             tick_q, tick_d;
  logic             in_dead;

  // With no dead time the comparison would be constant, so it is left out
  // entirely rather than comparing an unsigned count against zero.
  generate
    if (BLANK_CYC == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
      assign in_dead = (cnt_q < CNT_BLANK);
    end
  endgenerate

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    tick_d = 1'b0;
    an_d   = 4'b1111;
    if (bus.en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        sel_d  = sel_q + 2'd1;  // 3 wraps naturally to 0
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      // Anode decision uses the pre-edge slot state, so AN trails sel by
      // one cycle and the cathode mux is settled before the digit lights.
      if (!(in_dead || bus.blank_mask[sel_q])) begin
        an_d = ~(4'b0001 << sel_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sel_q  <= 2'd0;
      an_q   <= 4'b1111;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign bus.AN        = an_q;
  assign bus.digit_sel = sel_q;
  assign bus.slot_tick = tick_q;

endmodule

// File: tb/tb_anode_scanner.sv
module tb_anode_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] mask;

  always #5 clk = ~clk;

  anode_scanner_if ifa ();
  anode_scanner_if ifb ();

  assign ifa.en         = en;
  assign ifa.blank_mask = mask;
  assign ifb.en         = en;
  assign ifb.blank_mask = mask;

  // Instance A: REFRESH_DIV=8, BLANK_CYC=2. Instance B: zero dead time.
  anode_scanner #(.REFRESH_DIV(8), .BLANK_CYC(2), .CNT_W(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  anode_scanner #(.REFRESH_DIV(2), .BLANK_CYC(0), .CNT_W(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each instance is described by its absolute position
  // within the 4-slot scan period; slot and in-slot offset follow by
  // division and remainder.
  int         divs [2] = '{8, 2};
  int         blks [2] = '{2, 0};
  int         pos  [2];
  logic [3:0] an_m [2];
  logic       tick_m [2];
  logic [3:0] prev_a;

  function automatic logic [3:0] digit_pattern(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << s);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pos[k]    = 0;
        an_m[k]   = 4'b1111;
        tick_m[k] = 1'b0;
      end else if (en) begin
        int off, slot;
        off  = pos[k] % divs[k];
        slot = (pos[k] / divs[k]) % 4;
        if (off < blks[k] || mask[slot])
          an_m[k] = 4'b1111;
        else
          an_m[k] = digit_pattern(slot);
        tick_m[k] = (off == divs[k] - 1);
        pos[k]    = (pos[k] + 1) % (4 * divs[k]);
      end else begin
        an_m[k]   = 4'b1111;
        tick_m[k] = 1'b0;
      end
    end
  endtask

  function automatic int zeros(input logic [3:0] v);
    return 4 - $countones(v);
  endfunction

  task automatic compare_all();
    chk("a_an",   ifa.AN,        an_m[0]);
    chk("a_sel",  ifa.digit_sel, (pos[0] / divs[0]) % 4);
    chk("a_tick", ifa.slot_tick, tick_m[0]);
    chk("b_an",   ifb.AN,        an_m[1]);
    chk("b_sel",  ifb.digit_sel, (pos[1] / divs[1]) % 4);
    chk("b_tick", ifb.slot_tick, tick_m[1]);
    // At most one anode low, for both instances.
    if (zeros(ifa.AN) > 1) chk("a_onehot", zeros(ifa.AN), 1);
    if (zeros(ifb.AN) > 1) chk("b_onehot", zeros(ifb.AN), 1);
    // With dead time, no direct move between two lit digits.
    if (prev_a != 4'b1111 && ifa.AN != 4'b1111)
      chk("a_no_direct", ifa.AN, prev_a);
    prev_a = ifa.AN;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  logic [3:0] zd_seq [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                             4'b1011, 4'b1011, 4'b0111, 4'b0111};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    prev_a = 4'b1111;
    pos    = '{0, 0};
    an_m   = '{4'b1111, 4'b1111};
    tick_m = '{1'b0, 1'b0};
    rst_n  = 1'b0;
    en     = 1'b1;
    mask   = 4'b0000;
    @(negedge clk);

    // Reset state
    step();
    chk("rst_an",   ifa.AN,        4'b1111);
    chk("rst_sel",  ifa.digit_sel, 0);
    chk("rst_tick", ifa.slot_tick, 0);

    // First full scan after release, with fixed reference points
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step();
      if (e == 2)  chk("first_dead_end",  ifa.AN, 4'b1111);
      if (e == 3)  chk("first_digit0",    ifa.AN, 4'b1110);
      if (e == 8)  chk("first_tick_sel1", {ifa.slot_tick, ifa.digit_sel}, 3'b101);
      if (e == 9)  chk("slot1_dead",      ifa.AN, 4'b1111);
      if (e == 11) chk("slot1_digit1",    ifa.AN, 4'b1101);
      if (e == 19) chk("slot2_digit2",    ifa.AN, 4'b1011);
      if (e == 27) chk("slot3_digit3",    ifa.AN, 4'b0111);
      if (e == 32) chk("wrap_tick_sel0",  {ifa.slot_tick, ifa.digit_sel}, 3'b100);
      if (e <= 8)  chk("zero_dead_seq",   ifb.AN, zd_seq[e-1]);
      if (e <= 8)  chk("zero_dead_tick",  ifb.slot_tick, (e % 2 == 0));
    end

    // Blank mask on digits 2 and 3
    mask = 4'b1100;
    for (int e = 1; e <= 32; e++) begin
      step();
      if (e == 3)  chk("mask_digit0", ifa.AN, 4'b1110);
      if (e >= 17) chk("mask_dark",   ifa.AN, 4'b1111);
    end
    mask = 4'b0000;

    // Enable gap at slot 1, offset 5
    for (int e = 0; e < 13; e++) step();
    en = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      chk("gap_dark", ifa.AN, 4'b1111);
      chk("gap_sel",  ifa.digit_sel, 1);
    end
    en = 1'b1;
    step();
    chk("resume_digit1", ifa.AN, 4'b1101);
    step();
    step();
    chk("resume_tick", ifa.slot_tick, 1);

    // Reset mid-slot at slot 2, offset 4
    for (int e = 0; e < 4; e++) step();
    rst_n = 1'b0;
    step();
    chk("midrst_an",   ifa.AN,        4'b1111);
    chk("midrst_sel",  ifa.digit_sel, 0);
    chk("midrst_tick", ifa.slot_tick, 0);
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("midrst_restart", ifa.AN, 4'b1110);

    // Randomized run
    for (int i = 0; i < 2000; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
